div_scheduler: RTL

DIV_SCHEDULER -- requirements
Module: div_scheduler

---
 rtl/div_scheduler_pkg.sv | 20 ++
 rtl/div_scheduler_rr_arbiter.sv | 32 +++
 rtl/div_scheduler.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/div_scheduler_pkg.sv
// Shared definitions for div_scheduler.
// Holds the FSM state encoding and the divider watchdog limit (N+4 RUN cycles).
package div_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_REPORT = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    // Watchdog fires after this many RUN cycles beyond the operand width.
    localparam int WD_MARGIN = 4;

    function automatic int wd_limit(input int n);
        return n + WD_MARGIN;
    endfunction

endpackage

// File: rtl/div_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin grant among NREQ requesters.
// Ports: i_req   - request vector
//        i_ptr   - index with highest priority this cycle
//        o_grant - one-hot grant (all zero when no request)
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant
);

    logic w_found;
    int   w_idx;

    // Scan from i_ptr upward with wrap; first requester found wins.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = int'(i_ptr) + k;
            if (w_idx >= NREQ) w_idx = w_idx - NREQ;
            if (!w_found && i_req[w_idx[PW-1:0]]) begin
                o_grant[w_idx[PW-1:0]] = 1'b1;
                w_found                = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_scheduler.sv
// div_scheduler: shares one external serial divider among NREQ requesters.
// Ports: i_mclk/i_rst           - clock, synchronous active-high reset
//        i_req, i_req_dividend,
//        i_req_divisor          - per-requester level request and packed operands
//        o_ack, o_done          - one-hot pulses: operands latched / result valid
//        o_quotient, o_remainder, o_div_err - last result, held until next done
//        o_busy                 - FSM not in IDLE
//        o_div_en, o_div_dividend, o_div_divisor - drive the divider
//        i_div_quotient, i_div_remainder, i_div_zero, i_div_sync - divider results
module div_scheduler
    import div_scheduler_pkg::*;
#(
    parameter int N    = 16,
    parameter int NREQ = 4
) (
    input  logic              i_mclk,
    input  logic              i_rst,
    input  logic [NREQ-1:0]   i_req,
    input  logic [NREQ*N-1:0] i_req_dividend,
    input  logic [NREQ*N-1:0] i_req_divisor,
    output logic [NREQ-1:0]   o_ack,
    output logic [NREQ-1:0]   o_done,
    output logic [N-1:0]      o_quotient,
    output logic [N-1:0]      o_remainder,
    output logic              o_div_err,
    output logic              o_busy,
    output logic              o_div_en,
    output logic [N-1:0]      o_div_dividend,
    output logic [N-1:0]      o_div_divisor,
    input  logic [N-1:0]      i_div_quotient,
    input  logic [N-1:0]      i_div_remainder,
    input  logic              i_div_zero,
    input  logic              i_div_sync
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WD = wd_limit(N);
    localparam int CW = $clog2(WD + 1);

    state_t            r_state, w_next;
    logic [PW-1:0]     r_ptr;
    logic [NREQ-1:0]   r_gnt;
    logic [N-1:0]      r_dvd, r_dvs;
    logic [CW-1:0]     r_cnt;
    logic [NREQ-1:0]   r_ack, r_done;
    logic [N-1:0]      r_q, r_r;
    logic              r_err;

    logic [NREQ-1:0]   w_grant;
    logic [PW-1:0]     w_gidx;
    logic [N-1:0]      w_gdvd, w_gdvs;
    logic              w_timeout;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant)
    );

    // Winner index and its operands.
    always_comb begin
        w_gidx = '0;
        w_gdvd = '0;
        w_gdvs = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_gidx = PW'(i);
                w_gdvd = i_req_dividend[i*N +: N];
                w_gdvs = i_req_divisor[i*N +: N];
            end
        end
    end

    assign w_timeout = (r_cnt == CW'(WD));

    // State register
    always_ff @(posedge i_mclk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (|i_req) w_next = (w_gdvs == '0) ? ST_ERR : ST_LOAD;
            ST_LOAD:   w_next = ST_RUN;
            ST_RUN:    if (i_div_sync || i_div_zero || w_timeout) w_next = ST_REPORT;
            ST_REPORT: w_next = ST_IDLE;
            ST_ERR:    w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        o_busy   = (r_state != ST_IDLE);
        o_div_en = (r_state == ST_RUN);
    end

    // Datapath: grant bookkeeping, watchdog counter, result capture.
    // ack/done are registered so they are clean single-cycle pulses.
    always_ff @(posedge i_mclk) begin
        if (i_rst) begin
            r_ptr  <= '0;
            r_gnt  <= '0;
            r_dvd  <= '0;
            r_dvs  <= '0;
            r_cnt  <= '0;
            r_ack  <= '0;
            r_done <= '0;
            r_q    <= '0;
            r_r    <= '0;
            r_err  <= 1'b0;
        end else begin
            r_ack  <= '0;
            r_done <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (|i_req) begin
                        r_ack <= w_grant;
                        r_gnt <= w_grant;
                        r_dvd <= w_gdvd;
                        r_dvs <= w_gdvs;
                        r_ptr <= (w_gidx == PW'(NREQ - 1)) ? '0 : w_gidx + PW'(1);
                    end
                end
                ST_LOAD: r_cnt <= '0;
                ST_RUN: begin
                    r_cnt <= r_cnt + CW'(1);
                    // A real completion wins over a same-cycle watchdog expiry.
                    if (i_div_sync) begin
                        r_done <= r_gnt;
                        r_q    <= i_div_quotient;
                        r_r    <= i_div_remainder;
                        r_err  <= 1'b0;
                    end else if (i_div_zero || w_timeout) begin
                        r_done <= r_gnt;
                        r_q    <= '0;
                        r_r    <= '0;
                        r_err  <= 1'b1;
                    end
                end
                ST_ERR: begin
                    r_done <= r_gnt;
                    r_q    <= '1;
                    r_r    <= r_dvd;
                    r_err  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_ack          = r_ack;
    assign o_done         = r_done;
    assign o_quotient     = r_q;
    assign o_remainder    = r_r;
    assign o_div_err      = r_err;
    assign o_div_dividend = r_dvd;
    assign o_div_divisor  = r_dvs;

endmodule
